count_stream_monitor: RTL and testbench
=======================================

// Module: count_stream_monitor
// PURPOSE
//  Sits directly downstream of the free-running 4-bit up-counter and consumes its out bus every cycle.
//  Checks that each sample is exactly previous+1 (mod 2^CNT_W), and counts wrap-arounds and sequence errors.
//  Queues timestamped wrap/error events in a small FIFO, drained over a valid/ready port.
//  Used as the self-checking consumer stage in mixed-language simulation and as an on-chip health monitor.
// PARAMETERS
//  CNT_W       4   width of monitored count bus
//  STAT_W      8   width of wrap_count / err_count (saturating)
//  FIFO_DEPTH  4   event FIFO entries, power of 2, >=2
// PORTS
//  clk         in   1               clock, all logic on rising edge
//  rstn        in   1               synchronous, active-low reset
//  cnt_in      in   CNT_W           count value from upstream counter
//  mon_en      in   1               1 = sample/check cnt_in this cycle
//  clr         in   1               sync clear of stats, stickies, FIFO; returns FSM to IDLE
//  evt_valid   out  1               FIFO head valid
//  evt_ready   in   1               consumer accepts head when evt_valid & evt_ready
//  evt_type    out  2               2'b01 WRAP, 2'b10 ERR, others unused
//  evt_cnt     out  CNT_W           cnt_in value that raised the event
//  wrap_count  out  STAT_W          wraps seen, saturates at all-ones
//  err_count   out  STAT_W          sequence errors seen, saturates at all-ones
//  err_sticky  out  1               set on first error, held until clr/reset
//  drop_sticky out  1               set when an event is lost to a full FIFO
// BEHAVIOUR
//  Reset (rstn=0 at edge): FSM=IDLE, FIFO empty, evt_valid=0, evt_type=0, evt_cnt=0, wrap_count=0,
//   err_count=0, err_sticky=0, drop_sticky=0, last_q=0. rstn has priority over clr; clr over all else.
//  FSM: IDLE --mon_en=1--> TRACK (captures last_q<=cnt_in, no check, no event: priming sample).
//   TRACK --mon_en=1--> TRACK (check, then last_q<=cnt_in); any state --mon_en=0--> IDLE (re-prime, no false error).
//  Check in TRACK with mon_en=1, exp = last_q+1 truncated to CNT_W bits:
//   cnt_in==exp && last_q=={CNT_W{1}} -> WRAP event, wrap_count+1.
//   cnt_in==exp otherwise -> no event.  cnt_in!=exp -> ERR event, err_count+1, err_sticky=1;
//   resync to cnt_in (next exp = cnt_in+1), so one glitch gives at most 2 ERR events.
//  Latency: event pushed at the edge that samples cnt_in; evt_valid/evt_type/evt_cnt show it the next cycle.
//  FIFO: show-ahead, outputs = head entry, registered; evt_valid = !empty; pop on evt_valid&evt_ready.
//   Push allowed when not full, or when full with a pop in the same cycle (simultaneous push+pop when full keeps it full).
//   Push when full without a pop: event dropped, drop_sticky=1; counters still increment.
//   Push+pop when empty: legal, entry becomes valid next cycle. evt_* hold stable while evt_valid & !evt_ready.
//  Counters saturate, never wrap; a saturated counter still lets the event be queued.
//  clr or reset mid-stream: FIFO flushed (evt_valid=0 next cycle), in-flight event discarded, FSM IDLE.
// STRUCTURE
//  Package count_mon_pkg: typedef evt_type_t {EVT_NONE=2'b00, EVT_WRAP=2'b01, EVT_ERR=2'b10};
//   FSM state enum {ST_IDLE, ST_TRACK}; event struct {evt_type_t type; logic [CNT_W-1:0] cnt}.
//  Sub-module: sync_event_fifo (param WIDTH, DEPTH; push/full/pop/empty, show-ahead, sync active-low reset, flush).
//  Top: FSM + compare + saturating counters + stickies; instantiates one sync_event_fifo.
// TESTING
//  1 Feed counter 0..15,0..3 with mon_en=1, evt_ready=1 -> one WRAP evt_cnt=0 a cycle after sample 0; wrap_count=1, err_count=0.
//  2 Sequence 3,4,9,10 -> ERR evt_cnt=9 only; err_count=1, err_sticky=1; no ERR for 10 (resync).
//  3 evt_ready=0, force 6 errors, FIFO_DEPTH=4 -> 4 queued, drop_sticky=1, err_count=6; drain gives first 4 in order.
//  4 FIFO full, push + pop same cycle -> entry count stays 4, no drop, head advances by one.
//  5 mon_en low 3 cycles while counter runs, then high -> no ERR event, first sample re-primes.
//  6 clr (and separately rstn=0) with 3 queued events -> evt_valid=0 next cycle, all counts/stickies 0, FSM IDLE.

Source files
------------

// File: rtl/count_mon_pkg.sv
// Shared types for the count stream monitor: event codes, FSM states and
// the layout of a queued event.
package count_mon_pkg;

  localparam int EVT_TYPE_W = 2;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [EVT_TYPE_W-1:0] {
    EVT_NONE = 2'b00,
    EVT_WRAP = 2'b01,
    EVT_ERR  = 2'b10
  } evt_type_t;

  typedef enum logic {
    ST_IDLE,
    ST_TRACK
  } state_t;

  // A queued event is the type in the upper bits and the offending count
  // value in the lower bits; the top packs its FIFO words in this order.
  typedef struct packed {
    evt_type_t                evtType;
    logic [DEF_CNT_W-1:0]     cnt;
  } evt_t;

endpackage

// File: rtl/sync_event_fifo.sv
// Small show-ahead FIFO. The head entry is always presented on headData.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. Flush empties the FIFO and clears the storage.
module sync_event_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] headData
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_pushOk;
  logic             w_popOk;

  assign full     = (r_count == (AW+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign headData = r_mem[r_rdPtr];
  assign w_popOk  = pop & ~empty;
  assign w_pushOk = push & (~full | w_popOk);

  // Storage, pointers and occupancy; reset and flush both clear everything.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) begin
        r_mem[r_wrPtr] <= pushData;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      if (w_popOk) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_pushOk && !w_popOk) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_pushOk && w_popOk) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/count_stream_monitor.sv
// Consumes a free-running counter bus, checks each sample is previous+1,
// counts wraps and sequence errors, and queues timestamped events in a
// small FIFO drained over a valid/ready port.
module count_stream_monitor
  import count_mon_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int STAT_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              mon_en,
  input  logic              clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [1:0]        evt_type,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic [STAT_W-1:0] wrap_count,
  output logic [STAT_W-1:0] err_count,
  output logic              err_sticky,
  output logic              drop_sticky
);

  localparam int EW = EVT_TYPE_W + CNT_W;

  state_t            r_state;
  logic [CNT_W-1:0]  r_last;
  logic [STAT_W-1:0] r_wrapCount;
  logic [STAT_W-1:0] r_errCount;
  logic              r_errSticky;
  logic              r_dropSticky;

  logic [CNT_W-1:0]  w_exp;
  logic              w_push;
  evt_type_t         w_pushType;
  logic [EW-1:0]     w_pushData;
  logic [EW-1:0]     w_headData;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_drop;

  assign evt_valid   = ~w_empty;
  assign w_pop       = evt_valid & evt_ready;
  assign w_pushData  = {w_pushType, cnt_in};
  assign w_drop      = w_push & w_full & ~w_pop;
  assign evt_type    = w_headData[EW-1:CNT_W];
  assign evt_cnt     = w_headData[CNT_W-1:0];
  assign wrap_count  = r_wrapCount;
  assign err_count   = r_errCount;
  assign err_sticky  = r_errSticky;
  assign drop_sticky = r_dropSticky;

  // Compare the sample against last+1 and classify it; the priming sample
  // taken from IDLE never raises an event.
  always_comb begin
    w_exp      = r_last + CNT_W'(1);
    w_push     = 1'b0;
    w_pushType = EVT_NONE;
    if (r_state == ST_TRACK && mon_en) begin
      if (cnt_in == w_exp) begin
        if (r_last == '1) begin
          w_push     = 1'b1;
          w_pushType = EVT_WRAP;
        end
      end else begin
        w_push     = 1'b1;
        w_pushType = EVT_ERR;
      end
    end
  end

  // FSM, last-sample register, saturating statistics and sticky flags.
  // After an error the monitor resyncs to the sample just seen.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_state      <= ST_IDLE;
      r_last       <= '0;
      r_wrapCount  <= '0;
      r_errCount   <= '0;
      r_errSticky  <= 1'b0;
      r_dropSticky <= 1'b0;
    end else begin
      if (mon_en) begin
        r_state <= ST_TRACK;
        r_last  <= cnt_in;
      end else begin
        r_state <= ST_IDLE;
      end
      if (w_push && w_pushType == EVT_WRAP && r_wrapCount != '1) begin
        r_wrapCount <= r_wrapCount + STAT_W'(1);
      end
      if (w_push && w_pushType == EVT_ERR) begin
        r_errSticky <= 1'b1;
        if (r_errCount != '1) begin
          r_errCount <= r_errCount + STAT_W'(1);
        end
      end
      if (w_drop) begin
        r_dropSticky <= 1'b1;
      end
    end
  end

  sync_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (clr),
    .push     (w_push),
    .pushData (w_pushData),
    .full     (w_full),
    .pop      (w_pop),
    .empty    (w_empty),
    .headData (w_headData)
  );

endmodule

// File: tb/tb_count_stream_monitor.sv
// Directed bench for count_stream_monitor. Expected events are queued as
// stimulus is issued; a monitor pops and compares on every handshake.
module tb_count_stream_monitor;

  localparam logic [1:0] T_WRAP = 2'b01;
  localparam logic [1:0] T_ERR  = 2'b10;

  logic       clk;
  logic       rstn;
  logic [3:0] cnt_in;
  logic       mon_en;
  logic       clr;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_type;
  logic [3:0] evt_cnt;
  logic [7:0] wrap_count;
  logic [7:0] err_count;
  logic       err_sticky;
  logic       drop_sticky;

  logic [5:0] expQ [$];
  int         assertCount = 0;
  int         failCount   = 0;

  count_stream_monitor #(
    .CNT_W      (4),
    .STAT_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cnt_in      (cnt_in),
    .mon_en      (mon_en),
    .clr         (clr),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_type    (evt_type),
    .evt_cnt     (evt_cnt),
    .wrap_count  (wrap_count),
    .err_count   (err_count),
    .err_sticky  (err_sticky),
    .drop_sticky (drop_sticky)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor: every accepted event is compared with the queue head.
  initial begin
    logic [5:0] exp;
    forever begin
      @(negedge clk);
      if (rstn && !clr && evt_valid && evt_ready) begin
        assertCount++;
        if (expQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL unexpected_event: got type=%0d cnt=%0d, required no event", evt_type, evt_cnt);
        end else begin
          exp = expQ.pop_front();
          if ({evt_type, evt_cnt} !== exp) begin
            failCount++;
            $display("[TB] FAIL event_payload: got type=%0d cnt=%0d, required type=%0d cnt=%0d",
                     evt_type, evt_cnt, exp[5:4], exp[3:0]);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] cnt, input logic en, input logic rdy, input logic clrIn);
    @(posedge clk);
    #1;
    cnt_in    = cnt;
    mon_en    = en;
    evt_ready = rdy;
    clr       = clrIn;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic expectEvent(input logic [1:0] t, input logic [3:0] c);
    expQ.push_back({t, c});
  endtask

  // Hold ready high until every expected event has been seen, bounded.
  task automatic waitDrain(input string name);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 30 && expQ.size() != 0; k++) begin
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput(name, expQ.size(), 0);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_valid"}, evt_valid, 0);
    checkOutput({tag, "_type"}, evt_type, 0);
    checkOutput({tag, "_cnt"}, evt_cnt, 0);
    checkOutput({tag, "_wrap"}, wrap_count, 0);
    checkOutput({tag, "_err"}, err_count, 0);
    checkOutput({tag, "_errSticky"}, err_sticky, 0);
    checkOutput({tag, "_dropSticky"}, drop_sticky, 0);
  endtask

  initial begin
    rstn      = 1'b0;
    cnt_in    = 4'd0;
    mon_en    = 1'b0;
    clr       = 1'b1;
    evt_ready = 1'b0;

    // Reset state, with clr also asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkCleared("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    clr  = 1'b0;

    // 1: clean count 0..15,0..3 gives a single WRAP at sample 0
    expectEvent(T_WRAP, 4'd0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'(i % 16), 1'b1, 1'b1, 1'b0);
    end
    waitDrain("t1_drain");
    checkOutput("t1_wrap", wrap_count, 1);
    checkOutput("t1_err", err_count, 0);
    checkOutput("t1_errSticky", err_sticky, 0);

    // 2: 3,4,9,10 gives ERR at 9 only, then resync
    expectEvent(T_ERR, 4'd9);
    applyStimulus(4'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'd4, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'd9, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'd10, 1'b1, 1'b1, 1'b0);
    waitDrain("t2_drain");
    checkOutput("t2_err", err_count, 1);
    checkOutput("t2_errSticky", err_sticky, 1);
    checkOutput("t2_wrap", wrap_count, 1);

    // 3: six errors with ready low: four queued, two dropped
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(4'(2 * i), 1'b1, 1'b0, 1'b0);
      if (i <= 4) expectEvent(T_ERR, 4'(2 * i));
    end
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3_err", err_count, 6);
    checkOutput("t3_drop", drop_sticky, 1);
    checkOutput("t3_valid", evt_valid, 1);
    checkOutput("t3_headHeld", evt_cnt, 2);
    waitDrain("t3_drain");

    // 4: full FIFO, push and pop in the same cycle
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(4'(2 * i), 1'b1, 1'b0, 1'b0);
      expectEvent(T_ERR, 4'(2 * i));
    end
    expectEvent(T_ERR, 4'd0);
    applyStimulus(4'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t4_valid", evt_valid, 1);
    checkOutput("t4_headAdvanced", evt_cnt, 4);
    checkOutput("t4_drop", drop_sticky, 0);
    checkOutput("t4_err", err_count, 5);
    waitDrain("t4_drain");

    // 5: mon_en low for three cycles while the counter runs
    for (int i = 5; i <= 13; i++) begin
      applyStimulus(4'(i), (i < 8 || i > 10), 1'b1, 1'b0);
    end
    waitDrain("t5_drain");
    checkOutput("t5_err", err_count, 5);
    checkOutput("t5_valid", evt_valid, 0);

    // Error counter saturates at all-ones
    applyStimulus(4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) begin
      applyStimulus(4'd0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sat_err", err_count, 255);

    // 6a: clr with three queued events
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_queuedErr", err_count, 3);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkCleared("t6clr");
    applyStimulus(4'd9, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'd10, 1'b1, 1'b1, 1'b0);
    waitDrain("t6clr_drain");
    checkOutput("t6clr_reprime", err_count, 0);

    // 6b: rstn with three queued events
    applyStimulus(4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6rst_queued", evt_valid, 1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checkCleared("t6rst");
    applyStimulus(4'd12, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'd13, 1'b1, 1'b1, 1'b0);
    waitDrain("t6rst_drain");
    checkOutput("t6rst_reprime", err_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
